sp_ram_ctrl: RTL

//  Request-side controller placed directly upstream of sp_ram. Accepts independent write and

---
 rtl/sp_ram_pkg.sv | 26 ++
 rtl/sp_ram.sv | 38 +++
 rtl/sp_ram_rsp_fifo.sv | 64 ++++++
 rtl/sp_ram_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM request controller.
//  - state_e : controller FSM states (BOOT, CLEAR, RUN)
//  - grant_e : RAM port owner for the current cycle (NONE, WRITE, READ)
//  - rsp_depth_ok() : elaboration-time sanity check on the response FIFO depth
package sp_ram_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } grant_e;

    // A single-entry FIFO cannot absorb the two reads that may be in flight.
    localparam int unsigned MIN_RSP_DEPTH = 32'd2;

    function automatic bit rsp_depth_ok(input int unsigned depth);
        return depth >= MIN_RSP_DEPTH;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Behavioural single-port synchronous RAM (no reset; contents set by the controller's zero-fill).
// Ports:
//  clk   clock
//  en    port enable
//  wen   1 = write din to addr, 0 = read addr
//  addr  word address
//  din   write data
//  q     read data, valid the cycle after a read, high-impedance otherwise
module sp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] q_r;
    logic                  rd_vld_r;

    // Array write and registered read.
    always_ff @(posedge clk) begin
        if (en && wen) begin
            mem_r[addr] <= din;
        end
        if (en && !wen) begin
            q_r <= mem_r[addr];
        end
        rd_vld_r <= en && !wen;
    end

    assign q = rd_vld_r ? q_r : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sp_ram_rsp_fifo.sv
// Synchronous response FIFO for read data returned by the RAM.
// Ports:
//  clk, rst_n      clock / async active-low reset (contents, pointers, count cleared)
//  push, push_data write one entry (caller guarantees no overflow)
//  pop             remove head entry (caller guarantees non-empty)
//  head            current head entry (0 after reset)
//  count           number of stored entries
module sp_ram_rsp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/sp_ram_ctrl.sv
// Request-side controller in front of sp_ram. Arbitrates independent write and read
// request channels onto the single RAM port, zero-fills the RAM after reset or on
// clr_req, and returns read data through a response FIFO with backpressure.
// Ports:
//  clk, rst_n                       clock / async active-low reset
//  clr_req                          re-run zero-fill (RUN only); init_done = in RUN
//  wr_valid/wr_ready/wr_addr/wr_data write request channel
//  rd_valid/rd_ready/rd_addr         read request channel
//  rsp_valid/rsp_ready/rsp_data      read response channel (FIFO head)
//  ram_en/ram_wen/ram_addr/ram_din   RAM command, ram_q RAM read data
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  init_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_en,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

    generate
        if (!rsp_depth_ok(RSP_DEPTH)) begin : g_bad_rsp_depth
            $error("sp_ram_ctrl: RSP_DEPTH must be at least 2");
        end
    endgenerate

    state_e                state_r;
    state_e                state_next_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [ADDR_WIDTH-1:0] clr_addr_next_s;
    grant_e                last_grant_r;
    grant_e                grant_s;
    logic                  pending_r;
    logic                  rd_ok_s;
    logic [CW-1:0]         count_s;
    logic                  pop_s;

    // Credit check: reads in flight plus stored responses must leave room in the FIFO.
    // Uses only registered state so rsp_ready never reaches the request side.
    assign rd_ok_s = (32'(count_s) + 32'(pending_r)) < 32'(RSP_DEPTH);

    // Next-state, clear address and arbitration.
    always_comb begin
        state_next_s    = state_r;
        clr_addr_next_s = clr_addr_r;
        grant_s         = NONE;
        case (state_r)
            BOOT: begin
                state_next_s    = CLEAR;
                clr_addr_next_s = {ADDR_WIDTH{1'b0}};
            end
            CLEAR: begin
                clr_addr_next_s = clr_addr_r + ADDR_WIDTH'(1);
                if (clr_addr_r == CLR_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_next_s    = CLEAR;
                    clr_addr_next_s = {ADDR_WIDTH{1'b0}};
                end else if (wr_valid && rd_valid && rd_ok_s) begin
                    grant_s = (last_grant_r == WRITE) ? READ : WRITE;
                end else if (wr_valid) begin
                    grant_s = WRITE;
                end else if (rd_valid && rd_ok_s) begin
                    grant_s = READ;
                end else begin
                    grant_s = NONE;
                end
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // RAM command: zero-fill during CLEAR, otherwise the granted request.
    always_comb begin
        ram_en   = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = {ADDR_WIDTH{1'b0}};
        ram_din  = {DATA_WIDTH{1'b0}};
        if (state_r == CLEAR) begin
            ram_en   = 1'b1;
            ram_wen  = 1'b1;
            ram_addr = clr_addr_r;
        end else begin
            case (grant_s)
                WRITE: begin
                    ram_en   = 1'b1;
                    ram_wen  = 1'b1;
                    ram_addr = wr_addr;
                    ram_din  = wr_data;
                end
                READ: begin
                    ram_en   = 1'b1;
                    ram_addr = rd_addr;
                end
                default: begin
                    ram_en = 1'b0;
                end
            endcase
        end
    end

    // FSM state, clear address, read-in-flight flag and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= BOOT;
            clr_addr_r   <= {ADDR_WIDTH{1'b0}};
            pending_r    <= 1'b0;
            last_grant_r <= READ;
        end else begin
            state_r    <= state_next_s;
            clr_addr_r <= clr_addr_next_s;
            pending_r  <= (grant_s == READ);
            if (grant_s != NONE) begin
                last_grant_r <= grant_s;
            end
        end
    end

    assign init_done = (state_r == RUN);
    assign wr_ready  = (grant_s == WRITE);
    assign rd_ready  = (grant_s == READ);
    assign rsp_valid = (count_s != {CW{1'b0}});
    assign pop_s     = rsp_valid && rsp_ready;

    // ram_q is only captured in the cycle after a read grant.
    sp_ram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CW         (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending_r),
        .push_data (ram_q),
        .pop       (pop_s),
        .head      (rsp_data),
        .count     (count_s)
    );

endmodule
